// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB MIPS control FSM with memory handshake, wait timeout and sticky trap
module multicycle_controller #(
  parameter int MEM_WAIT_MAX = 15,
  parameter bit EN_OVF_TRAP  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       ovf,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IRWr,
  output logic       PCWr,
  output logic       RegWr,
  output logic       MemWr,
  output logic [1:0] RegDst,
  output logic [1:0] Mem2Reg,
  output logic [1:0] NPCSel,
  output logic [1:0] EXTOp,
  output logic       ALUSrc,
  output logic [2:0] ALUOp,
  output logic       SetFlag,
  output logic       ovf_flag,
  output logic       illegal,
  output logic       timeout,
  output logic [2:0] state
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001;
  localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011, FN_SLT = 6'b101010, FN_JR = 6'b001000;
  state_t state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic ovf_q, ovf_d, ovf_flag_q, ovf_flag_d, illegal_q, illegal_d, timeout_q, timeout_d;
  logic req, ir_wr, pc_wr, reg_wr, mem_wr, wait_hit, suppress;
  logic is_r, is_addu, is_subu, is_slt, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_addi, is_addiu, legal;
  assign is_r     = opcode == OP_R;
  assign is_addu  = is_r && funct == FN_ADDU;
  assign is_subu  = is_r && funct == FN_SUBU;
  assign is_slt   = is_r && funct == FN_SLT;
  assign is_jr    = is_r && funct == FN_JR;
  assign is_ori   = opcode == OP_ORI;
  assign is_lui   = opcode == OP_LUI;
  assign is_lw    = opcode == OP_LW;
  assign is_sw    = opcode == OP_SW;
  assign is_beq   = opcode == OP_BEQ;
  assign is_j     = opcode == OP_J;
  assign is_jal   = opcode == OP_JAL;
  assign is_addi  = opcode == OP_ADDI;
  assign is_addiu = opcode == OP_ADDIU;
  assign legal = is_addu | is_subu | is_slt | is_jr | is_ori | is_lui | is_lw | is_sw | is_beq | is_j | is_jal | is_addi | is_addiu;
  assign RegDst  = (is_addu | is_subu | is_slt) ? 2'b01 : is_jal ? 2'b10 : 2'b00;
  assign ALUSrc  = is_ori | is_lui | is_lw | is_sw | is_addi | is_addiu;
  assign Mem2Reg = is_lw ? 2'b01 : is_jal ? 2'b10 : 2'b00;
  assign NPCSel  = is_beq ? {1'b0, zero} : (is_j | is_jal) ? 2'b10 : is_jr ? 2'b11 : 2'b00;
  assign EXTOp   = is_lui ? 2'b10 : (is_lw | is_sw | is_addi | is_addiu) ? 2'b01 : 2'b00;
  assign ALUOp   = (is_subu | is_beq) ? 3'b001 : is_slt ? 3'b100 : (is_ori | is_lui) ? 3'b011 : (is_jal | is_jr) ? 3'b101 : 3'b000;
  assign SetFlag = is_addi;
  // A memory phase gives up on the cycle the wait count would reach the limit, unless ready arrives then
  assign wait_hit = wait_cnt_q == 8'(MEM_WAIT_MAX - 1);
  assign suppress = EN_OVF_TRAP && SetFlag && ovf_q;
  // Next state, sticky flags and per-state strobes
  always_comb begin
    state_d    = state_q;
    ovf_d      = ovf_q;
    ovf_flag_d = ovf_flag_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    req        = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    case (state_q)
      FETCH: begin
        req = 1'b1;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          state_d = DECODE;
        end else if (wait_hit) begin
          timeout_d = 1'b1;
          state_d   = TRAP;
        end
      end
      DECODE: begin
        if (!legal) begin
          illegal_d = 1'b1;
          state_d   = TRAP;
        end else if (is_j | is_jal) begin
          pc_wr   = 1'b1;
          reg_wr  = is_jal;
          state_d = FETCH;
        end else state_d = EXEC;
      end
      EXEC: begin
        ovf_d = ovf;
        if (is_beq | is_jr) begin
          pc_wr   = 1'b1;
          state_d = FETCH;
        end else if (is_lw | is_sw) state_d = MEM;
        else state_d = WB;
      end
      MEM: begin
        req = 1'b1;
        if (mem_ready) begin
          mem_wr = is_sw;
          pc_wr  = is_sw;
          if (is_sw) state_d = FETCH;
          else state_d = WB;
        end else if (wait_hit) begin
          timeout_d = 1'b1;
          state_d   = TRAP;
        end
      end
      WB: begin
        reg_wr     = ~suppress;
        ovf_flag_d = ovf_flag_q | suppress;
        pc_wr      = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = TRAP;
    endcase
    wait_cnt_d = (req && !mem_ready && !wait_hit) ? wait_cnt_q + 8'd1 : 8'd0;
  end
  // State and sticky flag registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      wait_cnt_q <= 8'd0;
      ovf_q      <= 1'b0;
      ovf_flag_q <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ovf_q      <= ovf_d;
      ovf_flag_q <= ovf_flag_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end
  assign mem_req  = rst_n & req;
  assign IRWr     = rst_n & ir_wr;
  assign PCWr     = rst_n & pc_wr;
  assign RegWr    = rst_n & reg_wr;
  assign MemWr    = rst_n & mem_wr;
  assign ovf_flag = ovf_flag_q;
  assign illegal  = illegal_q;
  assign timeout  = timeout_q;
  assign state    = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and randomized checks of the multicycle controller against an instruction-level model
module tb_multicycle_controller;
  localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001;
  localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011, FN_SLT = 6'b101010, FN_JR = 6'b001000;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, ovf = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic mem_req, IRWr, PCWr, RegWr, MemWr, ALUSrc, SetFlag, ovf_flag, illegal, timeout;
  logic [1:0] RegDst, Mem2Reg, NPCSel, EXTOp;
  logic [2:0] ALUOp, state;
  int passed = 0, total = 0, fails = 0;
  logic exp_flag = 1'b0;
  logic [5:0] ops [13] = '{OP_R, OP_R, OP_R, OP_R, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI, OP_ADDIU};
  logic [5:0] fns [13] = '{FN_ADDU, FN_SUBU, FN_SLT, FN_JR, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
  always #5 clk = ~clk;
  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .ovf(ovf), .mem_ready(mem_ready),
    .mem_req(mem_req), .IRWr(IRWr), .PCWr(PCWr), .RegWr(RegWr), .MemWr(MemWr), .RegDst(RegDst), .Mem2Reg(Mem2Reg),
    .NPCSel(NPCSel), .EXTOp(EXTOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .SetFlag(SetFlag), .ovf_flag(ovf_flag),
    .illegal(illegal), .timeout(timeout), .state(state)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Enters and leaves at a negedge; the DUT is in FETCH on return
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_flag = 1'b0;
  endtask
  function automatic int base_lat(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_J || op == OP_JAL) return 2;
    if (op == OP_BEQ || (op == OP_R && fn == FN_JR)) return 3;
    if (op == OP_LW) return 5;
    return 4;
  endfunction
  function automatic logic writes_reg(input logic [5:0] op, input logic [5:0] fn, input logic ov);
    if (op == OP_R) return fn != FN_JR;
    if (op == OP_ADDI) return !ov;
    return op == OP_ORI || op == OP_LUI || op == OP_LW || op == OP_ADDIU || op == OP_JAL;
  endfunction
  // Plays one instruction from FETCH with a memory that answers after fw / mw wait cycles and tallies the strobes
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov,
                           input int fw, input int mw, output int cycles, output int reqc, output int irw,
                           output int pcw, output int rgw, output int mmw, output logic [1:0] npc,
                           output logic [1:0] rdst, output logic [1:0] m2r, output logic done);
    int phase, wc;
    logic rdy;
    cycles = 0; reqc = 0; irw = 0; pcw = 0; rgw = 0; mmw = 0;
    npc = 2'bxx; rdst = 2'bxx; m2r = 2'bxx; done = 1'b0; phase = 0; wc = 0;
    opcode = op; funct = fn; zero = z; ovf = ov;
    while (!done && cycles < 100 && state !== 3'd5) begin
      #1;
      rdy = mem_req && wc == (phase == 0 ? fw : mw);
      mem_ready = rdy;
      #1;
      cycles++;
      reqc += int'(mem_req); irw += int'(IRWr); pcw += int'(PCWr); rgw += int'(RegWr); mmw += int'(MemWr);
      if (RegWr) begin
        rdst = RegDst;
        m2r = Mem2Reg;
      end
      if (mem_req) begin
        if (rdy) begin
          phase++;
          wc = 0;
        end else wc++;
      end
      if (PCWr) begin
        npc = NPCSel;
        done = 1'b1;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask
  task automatic check_instr(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input logic ov, input int fw, input int mw);
    int cycles, reqc, irw, pcw, rgw, mmw;
    logic [1:0] npc, rdst, m2r, enpc;
    logic done, memop, wr;
    run_instr(op, fn, z, ov, fw, mw, cycles, reqc, irw, pcw, rgw, mmw, npc, rdst, m2r, done);
    memop = op == OP_LW || op == OP_SW;
    wr = writes_reg(op, fn, ov);
    enpc = op == OP_BEQ ? {1'b0, z} : (op == OP_J || op == OP_JAL) ? 2'b10 : (op == OP_R && fn == FN_JR) ? 2'b11 : 2'b00;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".cycles"}, 32'(cycles), 32'(base_lat(op, fn) + fw + (memop ? mw : 0)));
    chk({tag, ".req_cycles"}, 32'(reqc), 32'(fw + 1 + (memop ? mw + 1 : 0)));
    chk({tag, ".IRWr"}, 32'(irw), 32'd1);
    chk({tag, ".PCWr"}, 32'(pcw), 32'd1);
    chk({tag, ".RegWr"}, 32'(rgw), 32'(wr));
    chk({tag, ".MemWr"}, 32'(mmw), 32'(op == OP_SW));
    chk({tag, ".NPCSel"}, 32'(npc), 32'(enpc));
    if (wr) begin
      chk({tag, ".RegDst"}, 32'(rdst), op == OP_JAL ? 32'd2 : (op == OP_R ? 32'd1 : 32'd0));
      chk({tag, ".Mem2Reg"}, 32'(m2r), op == OP_JAL ? 32'd2 : (op == OP_LW ? 32'd1 : 32'd0));
    end
    exp_flag = exp_flag | (op == OP_ADDI && ov);
    chk({tag, ".ovf_flag"}, 32'(ovf_flag), 32'(exp_flag));
    chk({tag, ".state_end"}, 32'(state), 32'd0);
    chk({tag, ".illegal"}, 32'(illegal), 32'd0);
    chk({tag, ".timeout"}, 32'(timeout), 32'd0);
  endtask
  initial begin
    int st [4] = '{0, 1, 2, 4};
    // Reset: strobes held low even with mem_ready high
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("rst.IRWr", 32'(IRWr), 32'd0);
    chk("rst.PCWr", 32'(PCWr), 32'd0);
    chk("rst.RegWr", 32'(RegWr), 32'd0);
    chk("rst.MemWr", 32'(MemWr), 32'd0);
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.flags", {29'd0, ovf_flag, illegal, timeout}, 32'd0);
    // ADDU with an always-ready memory: 0,1,2,4 then back to FETCH
    do_reset();
    opcode = OP_R; funct = FN_ADDU; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("addu.state%0d", c), 32'(state), 32'(st[c]));
      chk($sformatf("addu.IRWr%0d", c), 32'(IRWr), 32'(c == 0));
      chk($sformatf("addu.RegWr%0d", c), 32'(RegWr), 32'(c == 3));
      chk($sformatf("addu.PCWr%0d", c), 32'(PCWr), 32'(c == 3));
      if (c == 3) begin
        chk("addu.RegDst", 32'(RegDst), 32'd1);
        chk("addu.ALUOp", 32'(ALUOp), 32'd0);
        chk("addu.ALUSrc", 32'(ALUSrc), 32'd0);
        mem_ready = 1'b0;
      end
      @(negedge clk);
    end
    chk("addu.back_to_fetch", 32'(state), 32'd0);
    // LW with three data wait states
    do_reset();
    check_instr("lw_wait3", OP_LW, 6'd0, 1'b0, 1'b0, 0, 3);
    // BEQ taken and not taken
    check_instr("beq_z1", OP_BEQ, 6'd0, 1'b1, 1'b0, 0, 0);
    check_instr("beq_z0", OP_BEQ, 6'd0, 1'b0, 1'b0, 0, 0);
    // ADDI overflow suppression stays sticky; ADDIU overflow writes normally
    check_instr("addi_ovf", OP_ADDI, 6'd0, 1'b0, 1'b1, 0, 0);
    check_instr("addu_after_ovf", OP_R, FN_ADDU, 1'b0, 1'b0, 1, 0);
    do_reset();
    check_instr("addiu_ovf", OP_ADDIU, 6'd0, 1'b0, 1'b1, 0, 0);
    // Fetch never answered: still FETCH after 14 waits, TRAP after 15
    do_reset();
    opcode = OP_R; funct = FN_ADDU;
    repeat (14) @(posedge clk);
    #1;
    chk("to.state14", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    chk("to.state15", 32'(state), 32'd5);
    chk("to.timeout", 32'(timeout), 32'd1);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("to.trap_outputs", {27'd0, mem_req, IRWr, PCWr, RegWr, MemWr}, 32'd0);
    @(negedge clk);
    chk("to.absorbing", 32'(state), 32'd5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    chk("to.rst_state", 32'(state), 32'd0);
    chk("to.rst_flags", {29'd0, ovf_flag, illegal, timeout}, 32'd0);
    // Ready on the 15th wait cycle completes normally
    do_reset();
    repeat (14) @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("ready_wins.IRWr", 32'(IRWr), 32'd1);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    chk("ready_wins.state", 32'(state), 32'd1);
    chk("ready_wins.timeout", 32'(timeout), 32'd0);
    // Illegal opcode traps
    do_reset();
    opcode = 6'b111111; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ill.state", 32'(state), 32'd5);
    chk("ill.illegal", 32'(illegal), 32'd1);
    chk("ill.outputs", {27'd0, mem_req, IRWr, PCWr, RegWr, MemWr}, 32'd0);
    // SW: reset lands in MEM exactly as ready arrives
    do_reset();
    opcode = OP_SW; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("swrst.in_mem", 32'(state), 32'd3);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("swrst.MemWr", 32'(MemWr), 32'd0);
    chk("swrst.PCWr", 32'(PCWr), 32'd0);
    @(posedge clk);
    #1;
    chk("swrst.state", 32'(state), 32'd0);
    // Random instruction stream with random wait states
    do_reset();
    for (int n = 0; n < 40; n++) begin
      int k;
      k = int'($urandom_range(12));
      check_instr($sformatf("rnd%0d_op%0h_fn%0h", n, ops[k], fns[k]), ops[k], fns[k], 1'($urandom),
                  1'($urandom), int'($urandom_range(4)), int'($urandom_range(4)));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
